// File: rtl/pw_change_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pw_change_ctrl
// Brief    : Keypad-driven password-change sequencer (verify, new, confirm,
//            commit) that also holds the stored BCD password for the lock.
// Revision : 1.0
// ============================================================================
module pw_change_ctrl #(
    parameter int                   DIGITS      = 6,
    parameter logic [4*DIGITS-1:0]  DEF_PW      = 24'h123456,
    parameter int                   TIMEOUT_CYC = 50000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    output logic                    change,
    output logic [4*DIGITS-1:0]     pw_out,
    output logic [4*DIGITS-1:0]     entry_buf,
    output logic [2:0]              digit_cnt,
    output logic                    done,
    output logic                    err
);

    localparam int         c_W     = 4 * DIGITS;
    localparam int         c_TW    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_TW-1:0] c_TLAST = c_TW'(TIMEOUT_CYC - 1);
    localparam logic [2:0] c_FULL  = 3'(DIGITS);
    localparam logic [3:0] c_KEY_STAR = 4'd10;
    localparam logic [3:0] c_KEY_HASH = 4'd11;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_VERIFY = 2'd1;
    localparam logic [1:0] c_ST_NEW1   = 2'd2;
    localparam logic [1:0] c_ST_NEW2   = 2'd3;

    logic [1:0]      r_state;
    logic [c_W-1:0]  r_buf;
    logic [2:0]      r_cnt;
    logic [c_W-1:0]  r_pw;
    logic [c_W-1:0]  r_new_pw;
    logic [c_TW-1:0] r_tcnt;
    logic            r_change;
    logic            r_done;
    logic            r_err;

    logic [1:0]      w_state_n;
    logic [c_W-1:0]  w_buf_n;
    logic [2:0]      w_cnt_n;
    logic [c_W-1:0]  w_pw_n;
    logic [c_W-1:0]  w_new_pw_n;
    logic [c_TW-1:0] w_tcnt_n;
    logic            w_done_n;
    logic            w_err_n;
    logic            w_clear;
    logic            w_is_digit;
    logic            w_full;

    assign w_is_digit = (key_code <= 4'd9);
    assign w_full     = (r_cnt == c_FULL);

    always_comb begin
        w_state_n  = r_state;
        w_buf_n    = r_buf;
        w_cnt_n    = r_cnt;
        w_pw_n     = r_pw;
        w_new_pw_n = r_new_pw;
        w_tcnt_n   = r_tcnt;
        w_done_n   = 1'b0;
        w_err_n    = 1'b0;
        w_clear    = 1'b0;

        if (r_state == c_ST_IDLE) begin
            w_tcnt_n = '0;
            if (key_valid && key_code == c_KEY_STAR) begin
                w_state_n = c_ST_VERIFY;
                w_clear   = 1'b1;
            end
        end else if (key_valid) begin
            // Any key, even an ignored code, proves the user is still there.
            w_tcnt_n = '0;
            if (w_is_digit) begin
                if (!w_full) begin
                    w_buf_n = {r_buf[c_W-5:0], key_code};
                    w_cnt_n = r_cnt + 3'd1;
                end
            end else if (key_code == c_KEY_STAR) begin
                w_clear = 1'b1;
            end else if (key_code == c_KEY_HASH) begin
                w_clear   = 1'b1;
                w_state_n = c_ST_IDLE;
                if (!w_full) begin
                    w_err_n = 1'b1;
                end else begin
                    case (r_state)
                        c_ST_VERIFY: begin
                            if (r_buf == r_pw) w_state_n = c_ST_NEW1;
                            else               w_err_n   = 1'b1;
                        end
                        c_ST_NEW1: begin
                            w_new_pw_n = r_buf;
                            w_state_n  = c_ST_NEW2;
                        end
                        default: begin
                            if (r_buf == r_new_pw) begin
                                w_pw_n   = r_new_pw;
                                w_done_n = 1'b1;
                            end else begin
                                w_err_n  = 1'b1;
                            end
                        end
                    endcase
                end
            end
        end else if (r_tcnt == c_TLAST) begin
            w_err_n   = 1'b1;
            w_state_n = c_ST_IDLE;
            w_clear   = 1'b1;
            w_tcnt_n  = '0;
        end else begin
            w_tcnt_n = r_tcnt + 1'b1;
        end

        if (w_clear) begin
            w_buf_n = '0;
            w_cnt_n = 3'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_buf    <= '0;
            r_cnt    <= 3'd0;
            r_pw     <= DEF_PW;
            r_new_pw <= '0;
            r_tcnt   <= '0;
            r_change <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_buf    <= w_buf_n;
            r_cnt    <= w_cnt_n;
            r_pw     <= w_pw_n;
            r_new_pw <= w_new_pw_n;
            r_tcnt   <= w_tcnt_n;
            r_change <= (w_state_n != c_ST_IDLE);
            r_done   <= w_done_n;
            r_err    <= w_err_n;
        end
    end

    assign change    = r_change;
    assign pw_out    = r_pw;
    assign entry_buf = r_buf;
    assign digit_cnt = r_cnt;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pw_change_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pw_change_ctrl
// Brief    : Directed bench for pw_change_ctrl with a per-cycle reference model.
// Revision : 1.0
// ============================================================================
module tb_pw_change_ctrl;

    localparam int c_TO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        change;
    logic [23:0] pw_out;
    logic [23:0] entry_buf;
    logic [2:0]  digit_cnt;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int done_seen = 0;
    bit armed = 1'b0;

    pw_change_ctrl #(.DIGITS(6), .DEF_PW(24'h123456), .TIMEOUT_CYC(c_TO)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .change(change), .pw_out(pw_out), .entry_buf(entry_buf),
        .digit_cnt(digit_cnt), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: session stage, typed digits as a queue, idle-cycle count.
    int          m_stage;      // 0 idle, 1 verify, 2 new, 3 confirm
    logic [3:0]  m_q[$];
    logic [23:0] m_pw, m_new;
    int          m_idle;
    bit          m_done, m_err;

    function automatic logic [23:0] m_val();
        logic [23:0] v = 24'h0;
        foreach (m_q[i]) v = {v[19:0], m_q[i]};
        return v;
    endfunction

    task automatic m_abort(input bit e);
        m_stage = 0;
        m_q.delete();
        m_err = e;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_stage = 0; m_q.delete(); m_pw = 24'h123456; m_new = 24'h0;
            m_idle = 0; m_done = 0; m_err = 0;
        end else begin
            m_done = 0; m_err = 0;
            if (m_stage == 0) begin
                m_idle = 0;
                if (key_valid && key_code == 4'd10) begin
                    m_stage = 1; m_q.delete();
                end
            end else if (key_valid) begin
                m_idle = 0;
                if (key_code < 4'd10) begin
                    if (m_q.size() < 6) m_q.push_back(key_code);
                end else if (key_code == 4'd10) begin
                    m_q.delete();
                end else if (key_code == 4'd11) begin
                    if (m_q.size() != 6) m_abort(1);
                    else if (m_stage == 1) begin
                        if (m_val() == m_pw) begin m_stage = 2; m_q.delete(); end
                        else m_abort(1);
                    end else if (m_stage == 2) begin
                        m_new = m_val(); m_stage = 3; m_q.delete();
                    end else begin
                        if (m_val() == m_new) begin m_pw = m_new; m_abort(0); m_done = 1; end
                        else m_abort(1);
                    end
                end
            end else begin
                m_idle++;
                if (m_idle == c_TO) begin m_abort(1); m_idle = 0; end
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            cmp("model_change", 32'(change), 32'(m_stage != 0));
            cmp("model_pw", 32'(pw_out), 32'(m_pw));
            cmp("model_buf", 32'(entry_buf), 32'(m_val()));
            cmp("model_cnt", 32'(digit_cnt), 32'(m_q.size()));
            cmp("model_done", 32'(done), 32'(m_done));
            cmp("model_err", 32'(err), 32'(m_err));
            if (done === 1'b1) done_seen++;
        end
    end

    // Stimulus always runs aligned to posedge+2.
    task automatic key(input logic [3:0] c);
        key_valid = 1'b1; key_code = c;
        @(posedge clk); #2;
        key_valid = 1'b0; key_code = 4'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic keys(input logic [23:0] v);
        logic [23:0] t = v;
        for (int i = 0; i < 6; i++) begin
            key(t[23:20]);
            t = t << 4;
        end
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        armed = 1'b1;
        @(posedge clk); #2;
        cmp("reset_pw", 32'(pw_out), 32'h123456);
        cmp("reset_change", 32'(change), 32'h0);
        rst = 1'b0;
        idle(2);

        // Full successful change; last '#' comes back-to-back with digits.
        key(4'd10);
        cmp("star_change", 32'(change), 32'h1);
        keys(24'h123456);
        cmp("verify_buf", 32'(entry_buf), 32'h123456);
        key(4'd11);
        cmp("new1_cnt", 32'(digit_cnt), 32'h0);
        cmp("new1_change", 32'(change), 32'h1);
        keys(24'h987654); key(4'd11);
        keys(24'h987654); key(4'd11);
        cmp("commit_done", 32'(done), 32'h1);
        cmp("commit_change", 32'(change), 32'h0);
        cmp("commit_pw", 32'(pw_out), 32'h987654);
        idle(3);
        cmp("done_once", 32'(done_seen), 32'h1);

        // Asynchronous reset while in NEW2.
        key(4'd10); keys(24'h987654); key(4'd11); keys(24'h555555); key(4'd11);
        keys(24'h555555);
        #1 rst = 1'b1;
        #1;
        cmp("arst_change", 32'(change), 32'h0);
        cmp("arst_pw", 32'(pw_out), 32'h123456);
        cmp("arst_buf", 32'(entry_buf), 32'h0);
        cmp("arst_cnt", 32'(digit_cnt), 32'h0);
        @(posedge clk); #2 rst = 1'b0;
        idle(2);

        // Wrong old password.
        key(4'd10); keys(24'h111111); key(4'd11);
        cmp("badold_err", 32'(err), 32'h1);
        cmp("badold_change", 32'(change), 32'h0);
        idle(1);
        cmp("err_one_cycle", 32'(err), 32'h0);

        // Confirmation mismatch.
        key(4'd10); keys(24'h123456); key(4'd11);
        keys(24'h111111); key(4'd11);
        keys(24'h111112); key(4'd11);
        cmp("mismatch_err", 32'(err), 32'h1);
        cmp("mismatch_pw", 32'(pw_out), 32'h123456);
        idle(2);

        // Overflow digit ignored, restart, then short entry.
        key(4'd10); keys(24'h123456); key(4'd7);
        cmp("ovf_buf", 32'(entry_buf), 32'h123456);
        cmp("ovf_cnt", 32'(digit_cnt), 32'h6);
        key(4'd10);
        cmp("restart_buf", 32'(entry_buf), 32'h0);
        cmp("restart_change", 32'(change), 32'h1);
        key(4'd1); key(4'd2); key(4'd3); key(4'd11);
        cmp("short_err", 32'(err), 32'h1);
        idle(2);

        // Timeout: exact expiry, then keys on the last cycles keep it alive.
        key(4'd10);
        idle(c_TO - 1);
        cmp("to_not_yet", 32'(err), 32'h0);
        idle(1);
        cmp("to_err", 32'(err), 32'h1);
        cmp("to_change", 32'(change), 32'h0);
        idle(2);
        key(4'd10);
        idle(c_TO - 2); key(4'd15);
        idle(c_TO - 1); key(4'd14);
        cmp("to_key_wins", 32'(err), 32'h0);
        cmp("to_alive", 32'(change), 32'h1);
        idle(c_TO - 1);
        cmp("to_restart_quiet", 32'(err), 32'h0);
        idle(1);
        cmp("to_restart_err", 32'(err), 32'h1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
